// File: rtl/copper_bars_multi_if.sv
// copper_bars_multi_if: pixel-stream inputs and colour outputs of the copper bar block
interface copper_bars_multi_if;
    logic [10:0] pix_x_i;
    logic [10:0] pix_y_i;
    logic        pix_active_i;
    logic        pix_vblank_i;
    logic [2:0]  speed_i;
    logic        run_i;
    logic [7:0]  pix_r_o;
    logic [7:0]  pix_g_o;
    logic [7:0]  pix_b_o;
    logic        done_o;

    modport master (
        output pix_x_i, pix_y_i, pix_active_i, pix_vblank_i, speed_i, run_i,
        input  pix_r_o, pix_g_o, pix_b_o, done_o
    );

    modport slave (
        input  pix_x_i, pix_y_i, pix_active_i, pix_vblank_i, speed_i, run_i,
        output pix_r_o, pix_g_o, pix_b_o, done_o
    );
endinterface

// File: rtl/copper_bars_multi.sv
// copper_bars_multi: sine-bouncing tinted copper bars composited on the pixel stream; define COPPER_BARS_ZSORT_EN for depth sorting
module copper_bars_multi #(
    parameter int NUM_BARS   = 4,
    parameter int BAR_HALF   = 20,
    parameter int Y_BASE     = 113,
    parameter int PHASE_STEP = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic               clk_o,
    copper_bars_multi_if.slave bus
);
    // first half of the symmetric bump; the second half mirrors it
    localparam logic [6:0] HALF_WAVE [32] = '{
        7'd0,   7'd0,   7'd1,   7'd2,   7'd4,   7'd7,   7'd11,  7'd14,
        7'd19,  7'd23,  7'd29,  7'd34,  7'd40,  7'd46,  7'd52,  7'd58,
        7'd65,  7'd71,  7'd77,  7'd83,  7'd89,  7'd95,  7'd100, 7'd105,
        7'd110, 7'd114, 7'd117, 7'd120, 7'd123, 7'd125, 7'd126, 7'd126
    };

    typedef enum logic [1:0] {IDLE, WAIT_VB, ACTIVE, UPDATE} state_t;

    state_t      state_q;
    logic [5:0]  frame_q;
    logic [2:0]  idx_q;
    logic [8:0]  pos_q [NUM_BARS];
`ifdef COPPER_BARS_ZSORT_EN
    logic [6:0]  depth_q [NUM_BARS];
    logic [6:0]  depth_d;
    logic        found_w;
    logic [6:0]  best_w;
`endif
    logic [7:0]  r_q, g_q, b_q;
    logic        done_q;
    logic [5:0]  frame_d, phase_w;
    logic [8:0]  pos_d;
    logic [7:0]  r_d, g_d, b_d;
    logic [11:0] y_w, p_w;
    logic [5:0]  off_w;
    logic [9:0]  v_w;
    logic [7:0]  c_w;
    logic [2:0]  m_w;
    logic        cov_w;
    logic        vis_w;
    logic        unused_x;

    // 63-i equals ~i in six bits, so the upper half folds onto the table
    function automatic logic [6:0] wave(input logic [5:0] i);
        return HALF_WAVE[i[5] ? ~i[4:0] : i[4:0]];
    endfunction

    assign clk_o       = clk_i;
    assign unused_x    = ^bus.pix_x_i;
    assign vis_w       = (state_q == ACTIVE) && bus.pix_active_i && !bus.pix_vblank_i;
    assign bus.pix_r_o = r_q;
    assign bus.pix_g_o = g_q;
    assign bus.pix_b_o = b_q;
    assign bus.done_o  = done_q;

    // position of the bar being refreshed; the first update cycle already sees the advanced frame
    always_comb begin
        frame_d = (idx_q == 3'd0) ? frame_q + {3'b000, bus.speed_i} : frame_q;
        phase_w = frame_d + 6'(int'(idx_q) * PHASE_STEP);
        pos_d   = 9'(Y_BASE) + {1'b0, wave(phase_w), 1'b0};
`ifdef COPPER_BARS_ZSORT_EN
        depth_d = wave(phase_w + 6'd16);
`endif
    end

    // per-pixel compositing: later covering bars overwrite earlier ones unless depth says otherwise
    always_comb begin
        r_d   = '0;
        g_d   = '0;
        b_d   = '0;
        y_w   = {1'b0, bus.pix_y_i};
        p_w   = '0;
        off_w = '0;
        v_w   = '0;
        c_w   = '0;
        m_w   = '0;
        cov_w = 1'b0;
`ifdef COPPER_BARS_ZSORT_EN
        found_w = 1'b0;
        best_w  = '0;
`endif
        for (int i = 0; i < NUM_BARS; i++) begin
            p_w   = {3'b000, pos_q[i]};
            off_w = 6'(y_w - p_w + 12'd32);
            v_w   = 10'((int'(wave(off_w) >> 1) * (i + 5)) >> 3);
            c_w   = (v_w > 10'd63) ? 8'd255 : {v_w[5:0], 2'b00};
            m_w   = (3'(i + 1) == 3'd0) ? 3'd7 : 3'(i + 1);
            cov_w = (y_w + 12'(BAR_HALF) > p_w) && (y_w < p_w + 12'(BAR_HALF));
`ifdef COPPER_BARS_ZSORT_EN
            cov_w   = cov_w && (!found_w || depth_q[i] >= best_w);
            found_w = found_w | cov_w;
            best_w  = cov_w ? depth_q[i] : best_w;
`endif
            r_d = cov_w ? (m_w[2] ? c_w : 8'd0) : r_d;
            g_d = cov_w ? (m_w[1] ? c_w : 8'd0) : g_d;
            b_d = cov_w ? (m_w[0] ? c_w : 8'd0) : b_d;
        end
    end

    // control FSM, bar table refresh during vblank and registered colour/done outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            frame_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b1;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < NUM_BARS; i++) begin
                pos_q[i] <= '0;
`ifdef COPPER_BARS_ZSORT_EN
                depth_q[i] <= '0;
`endif
            end
        end else begin
            r_q <= vis_w ? r_d : 8'd0;
            g_q <= vis_w ? g_d : 8'd0;
            b_q <= vis_w ? b_d : 8'd0;
            case (state_q)
                IDLE: begin
                    if (bus.run_i) begin
                        state_q <= WAIT_VB;
                        done_q  <= 1'b0;
                    end
                end
                WAIT_VB: begin
                    if (!bus.pix_vblank_i) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.pix_vblank_i) begin
                        state_q <= UPDATE;
                        idx_q   <= '0;
                    end
                end
                UPDATE: begin
                    frame_q <= frame_d;
                    idx_q   <= idx_q + 3'd1;
                    for (int i = 0; i < NUM_BARS; i++) begin
                        if (idx_q == 3'(i)) begin
                            pos_q[i] <= pos_d;
`ifdef COPPER_BARS_ZSORT_EN
                            depth_q[i] <= depth_d;
`endif
                        end
                    end
                    if (idx_q == 3'(NUM_BARS - 1)) begin
                        state_q <= bus.run_i ? WAIT_VB : IDLE;
                        done_q  <= !bus.run_i;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/copper_bars_multi.md
# copper_bars_multi

Parametrised copper-bar generator: NUM_BARS horizontal bars bounce vertically on a 64-step sine path, each with its own RGB tint and intensity scale, composited per pixel on the VGA pixel stream. It sits between the VGA timing generator and the colour output stage, in the same slot as the single-colour four-bar frame display. New over that block: bar count, height and spacing are parameters; there is a per-bar tint, a variable speed input, and a registered output. Bar positions update sequentially during vblank, and optional depth sorting is available.

## Interface
- NUM_BARS, 4, number of bars, 1..8
- BAR_HALF, 20, bar half-height in lines, 1..31
- Y_BASE, 113, top of bar travel (line)
- PHASE_STEP, 8, wave-table phase offset between consecutive bars
- clock  in  1  pixel clock; out_clock = clock
- reset  in  1  asynchronous, active-low reset
- in_pix_x, in_pix_y  in  11 each  current pixel coordinate
- in_pix_active  in  1  pixel inside visible area
- in_pix_vblank  in  1  vertical blanking
- in_speed  in  3  frame-phase increment per vblank (0 = frozen)
- in_run  in  1  start/keep running
- out_pix_r, out_pix_g, out_pix_b  out  8 each  pixel colour, registered
- out_done  out  1  high while idle

## Operation
- Wave ROM: 64×7-bit symmetric bump, wave[i]=wave[63-i]. Peak 126 at i=31,32; 0 at i=0,1,62,63. Values come from the shared wave include file: wave[1]=0, wave[8]=19, wave[16]=65, wave[24]=110, wave[28]=123, wave[29]=125, wave[35]=123, wave[36]=120, wave[44]=83, wave[48]=58, wave[52]=34, wave[56]=14.
- State: frame (6-bit, wraps mod 64), pos[i] (9-bit), depth[i] (7-bit), bar index counter, FSM.
- FSM:
  - IDLE: out_done=1. Exits to WAIT_VB when in_run=1.
  - WAIT_VB: waits for in_pix_vblank=0, then goes to ACTIVE.
  - ACTIVE: draws pixels. On in_pix_vblank=1 goes to UPDATE.
  - UPDATE: takes NUM_BARS cycles.
    - First cycle: frame += in_speed (mod 64).
    - Cycle i: p = (frame + i·PHASE_STEP) & 63, using the already-updated frame. Sets pos[i] = Y_BASE + 2·wave[p] and depth[i] = wave[(p+16)&63].
    - After the last bar: if in_run=0 go to IDLE, else go to WAIT_VB.
  - UPDATE always completes, even if vblank ends during it.
- Pixel compositing, ACTIVE only:
  - Bar i covers line y when y+BAR_HALF > pos[i] and y < pos[i]+BAR_HALF, evaluated with 12-bit unsigned arithmetic.
  - Intensity: v = ((wave[y−pos[i]+32] >> 1) · (i+5)) >> 3, then c = min(255, v<<2).
  - Tint mask m = (i+1)&7, with 0 mapped to 7; bit2 = R, bit1 = G, bit0 = B. Each channel = c if its mask bit is set, else 0.
  - Winner among covering bars: highest index, unless modified by Configuration. No cover gives black.
- Black output in IDLE, WAIT_VB, UPDATE, and whenever in_pix_active=0 or in_pix_vblank=1.

## Timing
- Reset asserted, asynchronous:
  - state = IDLE, frame = 0, pos[] = 0, depth[] = 0.
  - All pix outputs = 0; out_done = 1.
- Reset mid-frame or mid-UPDATE abandons all work immediately.
- The first cycle after reset release is IDLE.
- Output latency: exactly 1 clock from the pix_* inputs to out_pix_*.
- in_run=1 → state leaves IDLE on the next clock; out_done falls in that same clock.
- in_speed is sampled only in the first UPDATE cycle.
- A vblank pulse shorter than NUM_BARS cycles still completes UPDATE; pixels stay black until WAIT_VB sees vblank low.

## Configuration
- COPPER_BARS_ZSORT_EN defined: among covering bars, the bar with the largest depth[i] wins; ties go to the higher index.
- COPPER_BARS_ZSORT_EN undefined: the highest covering index wins. depth[] registers are omitted.

## Test plan
- Reset, in_run=1, in_speed=1, one vblank:
  - Expect frame=1, pos = {113, 159, 255, 341}.
  - Pixel y=159 → g=188, r=b=0, one clock after the inputs.
- in_speed=0, first vblank, NUM_BARS=8, macro undefined:
  - Expect pos[7]=141.
  - y=141 → r=g=b=255 (saturated; bar7 wins over bar1).
- in_speed=7, four vblanks (frame=28):
  - Expect pos[0]=359, pos[1]=353.
  - y=356 with macro defined → b=152, r=g=0.
  - Macro undefined → g=180, r=b=0.
- in_speed=7, ten vblanks: frame wraps to 6. in_pix_active=0 at a bar's centre line → outputs 0 on the next clock.
- Vblank held only 2 cycles with NUM_BARS=4: UPDATE still finishes all four bars; outputs stay black during UPDATE.
- Reset pulsed low during UPDATE:
  - Outputs go to 0 immediately and out_done=1.
  - After release with in_run=0, the block stays IDLE.
